// File: rtl/ddr3_access_sched.sv
// ddr3_access_sched
// Round-robin arbiter for the single DDR3 user-side port. It picks one pending
// burst request, presents the command to the DDR3 core, counts data beats to
// completion and generates the ack / op-done handshake for the access buffer.
// All logic runs on i_ddr3_sclk; reset is synchronous and active-low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation owned; select the next requester round-robin
// CMD   | command presented (cmd_vld high), waiting for i_ddr3_cmd_rdy
// DATA  | command accepted, counting beats in the owner's direction
// DONE  | op_done / req_done pulse; grant released on the next edge

module ddr3_access_sched #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 28,
   parameter int LEN_W   = 8
) (
   input  logic                      i_ddr3_sclk,
   input  logic                      i_rst_n,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ-1:0]        i_req_wr_rdn,
   input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
   input  logic [NUM_REQ*LEN_W-1:0]  i_req_len,
   output logic [NUM_REQ-1:0]        o_grant,
   output logic [NUM_REQ-1:0]        o_req_done,
   output logic                      o_ddr3_cmd_vld,
   output logic                      o_ddr3_wr_rdn,
   output logic [ADDR_W-1:0]         o_ddr3_addr,
   output logic [LEN_W-1:0]          o_ddr3_len,
   input  logic                      i_ddr3_cmd_rdy,
   input  logic                      i_ddr3_wr_data_rdy,
   input  logic                      i_ddr3_rd_data_vld,
   output logic                      o_ddr3_ack,
   output logic                      o_ddr3_op_done,
   output logic                      o_busy
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   req_done_q, req_done_d;
   logic                 cmd_vld_q, cmd_vld_d;
   logic                 wr_rdn_q, wr_rdn_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic                 ack_q, ack_d;
   logic                 op_done_q, op_done_d;
   logic                 busy_q, busy_d;
   logic [LEN_W-1:0]     cnt_q, cnt_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]     owner_q, owner_d;

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [PTR_W-1:0]     pick_off;
   logic [PTR_W:0]       pick_sum;
   logic [PTR_W-1:0]     pick_idx;
   logic                 pick_vld;
   logic                 sel_wr_rdn;
   logic [ADDR_W-1:0]    sel_addr;
   logic [LEN_W-1:0]     sel_len;
   logic                 beat;

   // Round-robin pick: rotate requests so bit 0 is rr_ptr, take the lowest set bit.
   always_comb begin
      req_dbl  = {i_req, i_req} >> rr_ptr_q;
      req_rot  = req_dbl[NUM_REQ-1:0];
      pick_vld = 1'b0;
      pick_off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            pick_vld = 1'b1;
            pick_off = PTR_W'(i);
         end
      end
      pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
      if (pick_sum >= (PTR_W + 1)'(NUM_REQ)) begin
         pick_sum = pick_sum - (PTR_W + 1)'(NUM_REQ);
      end
      pick_idx = pick_sum[PTR_W-1:0];
   end

   // Mux the winning requester's command fields out of the packed buses.
   always_comb begin
      sel_wr_rdn = 1'b0;
      sel_addr   = '0;
      sel_len    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick_idx == PTR_W'(k)) begin
            sel_wr_rdn = i_req_wr_rdn[k];
            sel_addr   = i_req_addr[k*ADDR_W +: ADDR_W];
            sel_len    = i_req_len[k*LEN_W +: LEN_W];
         end
      end
   end

   // Only the strobe matching the operation direction counts as a beat.
   always_comb begin
      beat = wr_rdn_q ? i_ddr3_wr_data_rdy : i_ddr3_rd_data_vld;
   end

   // Next-state and next-output decode; every output is registered below.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      req_done_d = '0;
      cmd_vld_d  = 1'b0;
      wr_rdn_d   = wr_rdn_q;
      addr_d     = addr_q;
      len_d      = len_q;
      ack_d      = 1'b0;
      op_done_d  = 1'b0;
      cnt_d      = cnt_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;

      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d   = CMD;
               owner_d   = pick_idx;
               grant_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
               wr_rdn_d  = sel_wr_rdn;
               addr_d    = sel_addr;
               len_d     = sel_len;
               cmd_vld_d = 1'b1;
            end
         end
         CMD: begin
            if (i_ddr3_cmd_rdy) begin
               state_d = DATA;
               ack_d   = 1'b1;
               cnt_d   = len_q;
            end else begin
               cmd_vld_d = 1'b1;
            end
         end
         DATA: begin
            if (beat) begin
               if (cnt_q == '0) begin
                  state_d    = DONE;
                  op_done_d  = 1'b1;
                  req_done_d = grant_q;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         DONE: begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset abandons any in-flight burst silently.
   always_ff @(posedge i_ddr3_sclk) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         req_done_q <= '0;
         cmd_vld_q  <= 1'b0;
         wr_rdn_q   <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         ack_q      <= 1'b0;
         op_done_q  <= 1'b0;
         busy_q     <= 1'b0;
         cnt_q      <= '0;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         req_done_q <= req_done_d;
         cmd_vld_q  <= cmd_vld_d;
         wr_rdn_q   <= wr_rdn_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         ack_q      <= ack_d;
         op_done_q  <= op_done_d;
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
      end
   end

   assign o_grant        = grant_q;
   assign o_req_done     = req_done_q;
   assign o_ddr3_cmd_vld = cmd_vld_q;
   assign o_ddr3_wr_rdn  = wr_rdn_q;
   assign o_ddr3_addr    = addr_q;
   assign o_ddr3_len     = len_q;
   assign o_ddr3_ack     = ack_q;
   assign o_ddr3_op_done = op_done_q;
   assign o_busy         = busy_q;

endmodule

// File: tb/tb_ddr3_access_sched.sv
// Bench for ddr3_access_sched: directed scenarios, a transaction-level model
// of the scheduler compared against every output each cycle, and literal
// expectations for the key timing points of each scenario.

module tb_ddr3_access_sched;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 28;
   localparam int LEN_W   = 8;
   localparam int IDX_W   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      rst_n;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_wr;
   logic [ADDR_W-1:0]         t_addr [NUM_REQ];
   logic [LEN_W-1:0]          t_len  [NUM_REQ];
   logic [NUM_REQ*ADDR_W-1:0] req_addr_p;
   logic [NUM_REQ*LEN_W-1:0]  req_len_p;
   logic                      cmd_rdy, wr_rdy, rd_vld;

   logic [NUM_REQ-1:0]        o_grant, o_req_done;
   logic                      o_ddr3_cmd_vld, o_ddr3_wr_rdn;
   logic [ADDR_W-1:0]         o_ddr3_addr;
   logic [LEN_W-1:0]          o_ddr3_len;
   logic                      o_ddr3_ack, o_ddr3_op_done, o_busy;

   always_comb begin
      req_addr_p = '0;
      req_len_p  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         req_addr_p[k*ADDR_W +: ADDR_W] = t_addr[k];
         req_len_p[k*LEN_W +: LEN_W]    = t_len[k];
      end
   end

   ddr3_access_sched #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .i_ddr3_sclk        (clk),
      .i_rst_n            (rst_n),
      .i_req              (req),
      .i_req_wr_rdn       (req_wr),
      .i_req_addr         (req_addr_p),
      .i_req_len          (req_len_p),
      .o_grant            (o_grant),
      .o_req_done         (o_req_done),
      .o_ddr3_cmd_vld     (o_ddr3_cmd_vld),
      .o_ddr3_wr_rdn      (o_ddr3_wr_rdn),
      .o_ddr3_addr        (o_ddr3_addr),
      .o_ddr3_len         (o_ddr3_len),
      .i_ddr3_cmd_rdy     (cmd_rdy),
      .i_ddr3_wr_data_rdy (wr_rdy),
      .i_ddr3_rd_data_vld (rd_vld),
      .o_ddr3_ack         (o_ddr3_ack),
      .o_ddr3_op_done     (o_ddr3_op_done),
      .o_busy             (o_busy)
   );

   int n_pass  = 0;
   int n_total = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endfunction

   // ---------------- transaction-level model ----------------
   // One operation record: who owns the port, its captured fields, whether
   // the command was accepted, and how many beats are still owed.
   bit                m_active = 0, m_accepted = 0, m_done_cyc = 0, m_ack = 0;
   int                m_rr = 0, m_beats_left = 0;
   logic [IDX_W-1:0]  m_owner = '0, m_idx;
   logic              m_wr = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [LEN_W-1:0]  m_len = '0;
   logic [NUM_REQ-1:0] exp_grant = '0, exp_req_done = '0;
   logic              exp_cmd_vld = 1'b0, exp_busy = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_active = 0; m_accepted = 0; m_done_cyc = 0; m_ack = 0;
         m_rr = 0; m_beats_left = 0; m_owner = '0;
         m_wr = 1'b0; m_addr = '0; m_len = '0;
      end else begin
         m_ack = 0;
         if (!m_active) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               m_idx = IDX_W'((m_rr + k) % NUM_REQ);
               if (!m_active && req[m_idx]) begin
                  m_active     = 1;
                  m_accepted   = 0;
                  m_done_cyc   = 0;
                  m_owner      = m_idx;
                  m_wr         = req_wr[m_idx];
                  m_addr       = t_addr[m_idx];
                  m_len        = t_len[m_idx];
                  m_beats_left = int'(t_len[m_idx]) + 1;
               end
            end
         end else if (m_done_cyc) begin
            m_active   = 0;
            m_done_cyc = 0;
            m_rr       = (int'(m_owner) + 1) % NUM_REQ;
         end else if (!m_accepted) begin
            if (cmd_rdy) begin
               m_accepted = 1;
               m_ack      = 1;
            end
         end else if (m_wr ? wr_rdy : rd_vld) begin
            m_beats_left--;
            if (m_beats_left == 0) m_done_cyc = 1;
         end
      end
      exp_grant    = m_active ? (NUM_REQ'(1) << m_owner) : '0;
      exp_req_done = m_done_cyc ? (NUM_REQ'(1) << m_owner) : '0;
      exp_cmd_vld  = m_active && !m_accepted;
      exp_busy     = m_active;
   end

   // ---------------- per-cycle compare and event monitor ----------------
   int n_ack = 0, n_cmdvld = 0, n_opdone = 0;
   int grant_log[$];
   logic [NUM_REQ-1:0] prev_grant = '0;

   function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
      for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
      return -1;
   endfunction

   always @(posedge clk) begin
      #2;
      chk("grant",    o_grant,        exp_grant);
      chk("req_done", o_req_done,     exp_req_done);
      chk("cmd_vld",  o_ddr3_cmd_vld, exp_cmd_vld);
      chk("wr_rdn",   o_ddr3_wr_rdn,  m_wr);
      chk("addr",     o_ddr3_addr,    m_addr);
      chk("len",      o_ddr3_len,     m_len);
      chk("ack",      o_ddr3_ack,     m_ack);
      chk("op_done",  o_ddr3_op_done, m_done_cyc);
      chk("busy",     o_busy,         exp_busy);
      if (o_ddr3_ack === 1'b1) n_ack++;
      if (o_ddr3_cmd_vld === 1'b1) n_cmdvld++;
      if (o_ddr3_op_done === 1'b1) n_opdone++;
      if (o_grant !== '0 && prev_grant === '0) grant_log.push_back(onehot_idx(o_grant));
      prev_grant = o_grant;
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_sig(input string name, input int sel, input int budget);
      bit hit;
      hit = 0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         case (sel)
            0:       hit = (o_grant !== '0) && (o_grant !== 'x);
            1:       hit = (o_ddr3_ack === 1'b1);
            default: hit = (o_ddr3_op_done === 1'b1);
         endcase
      end
      if (!hit) begin
         n_total++;
         $display("FAIL %s: timeout after %0d cycles", name, budget);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"},    o_grant,        4'h0);
      chk({tag, "_req_done"}, o_req_done,     4'h0);
      chk({tag, "_cmd_vld"},  o_ddr3_cmd_vld, 1'b0);
      chk({tag, "_wr_rdn"},   o_ddr3_wr_rdn,  1'b0);
      chk({tag, "_addr"},     o_ddr3_addr,    28'h0);
      chk({tag, "_len"},      o_ddr3_len,     8'h0);
      chk({tag, "_ack"},      o_ddr3_ack,     1'b0);
      chk({tag, "_op_done"},  o_ddr3_op_done, 1'b0);
      chk({tag, "_busy"},     o_busy,         1'b0);
   endtask

   int base_ack, base_cmd, base_done, base_log;
   logic [19:0] rd_pat;

   initial begin
      rst_n = 1'b0; req = '0; req_wr = '0;
      cmd_rdy = 1'b0; wr_rdy = 1'b0; rd_vld = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         t_addr[k] = '0;
         t_len[k]  = '0;
      end
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single write, req0, addr 0x100, len 3, immediate cmd_rdy
      req_wr[0] = 1'b1; t_addr[0] = 28'h0000100; t_len[0] = 8'd3;
      cmd_rdy = 1'b1;
      base_ack = n_ack; base_cmd = n_cmdvld; base_done = n_opdone;
      req[0] = 1'b1;
      wait_sig("t1_ack", 1, 10);
      chk("t1_wr_rdn", o_ddr3_wr_rdn, 1'b1);
      chk("t1_addr", o_ddr3_addr, 28'h0000100);
      wr_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i < 3) chk("t1_early_done", o_ddr3_op_done, 1'b0);
      end
      chk("t1_op_done", o_ddr3_op_done, 1'b1);
      chk("t1_req_done", o_req_done, 4'b0001);
      req[0] = 1'b0; wr_rdy = 1'b0;
      @(negedge clk);
      chk("t1_grant_clr", o_grant, 4'b0000);
      chk("t1_ack_count", 64'(n_ack - base_ack), 64'd1);
      chk("t1_cmdvld_cycles", 64'(n_cmdvld - base_cmd), 64'd1);
      chk("t1_done_count", 64'(n_opdone - base_done), 64'd1);

      // Round-robin with all four requesters continuously pending
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req_wr = 4'b0101;
      t_len[0] = 8'd1; t_len[1] = 8'd0; t_len[2] = 8'd2; t_len[3] = 8'd0;
      t_addr[0] = 28'h0000A00; t_addr[1] = 28'h0000B10;
      t_addr[2] = 28'h0000C20; t_addr[3] = 28'h0000D30;
      cmd_rdy = 1'b1; wr_rdy = 1'b1; rd_vld = 1'b1;
      base_log = grant_log.size(); base_done = n_opdone;
      req = 4'b1111;
      for (int i = 0; i < 100 && (n_opdone - base_done) < 5; i++) @(negedge clk);
      chk("t2_done_count", 64'(n_opdone - base_done), 64'd5);
      req = 4'b0000;
      repeat (3) @(negedge clk);
      chk("t2_grant_count", 64'(grant_log.size() - base_log), 64'd5);
      if (grant_log.size() - base_log >= 5) begin
         chk("t2_order0", 64'(grant_log[base_log + 0]), 64'd0);
         chk("t2_order1", 64'(grant_log[base_log + 1]), 64'd1);
         chk("t2_order2", 64'(grant_log[base_log + 2]), 64'd2);
         chk("t2_order3", 64'(grant_log[base_log + 3]), 64'd3);
         chk("t2_order4", 64'(grant_log[base_log + 4]), 64'd0);
      end
      chk("t2_idle_grant", o_grant, 4'b0000);

      // Read with command backpressure and gappy data
      req_wr = 4'b0000; t_addr[2] = 28'hABCDE12; t_len[2] = 8'd7;
      cmd_rdy = 1'b0; wr_rdy = 1'b0; rd_vld = 1'b0;
      req[2] = 1'b1;
      wait_sig("t3_grant", 0, 10);
      for (int i = 0; i < 5; i++) begin
         chk("t3_wait_cmd_vld", o_ddr3_cmd_vld, 1'b1);
         chk("t3_wait_addr", o_ddr3_addr, 28'hABCDE12);
         chk("t3_wait_len", o_ddr3_len, 8'd7);
         t_addr[2] = 28'h1234560 + 28'(i);
         t_len[2]  = 8'hFF;
         req_wr[2] = 1'b1;
         wr_rdy    = ~wr_rdy;
         @(negedge clk);
      end
      cmd_rdy = 1'b1;
      wait_sig("t3_ack", 1, 5);
      chk("t3_dir_read", o_ddr3_wr_rdn, 1'b0);
      cmd_rdy = 1'b0;
      rd_pat = 20'h91865;
      for (int k = 0; k < 20; k++) begin
         chk("t3_early_done", o_ddr3_op_done, 1'b0);
         rd_vld = rd_pat[k];
         wr_rdy = ~wr_rdy;
         @(negedge clk);
      end
      chk("t3_op_done", o_ddr3_op_done, 1'b1);
      chk("t3_req_done", o_req_done, 4'b0100);
      req[2] = 1'b0; rd_vld = 1'b0; wr_rdy = 1'b0; req_wr[2] = 1'b0;
      @(negedge clk);

      // Withdrawn request while req3 owns the port
      req_wr[3] = 1'b1; t_addr[3] = 28'h0F00F00; t_len[3] = 8'd2;
      req_wr[1] = 1'b0; t_addr[1] = 28'h0001111; t_len[1] = 8'd4;
      cmd_rdy = 1'b1;
      base_log = grant_log.size();
      req[3] = 1'b1;
      wait_sig("t4_grant", 0, 10);
      chk("t4_owner", o_grant, 4'b1000);
      req[1] = 1'b1;
      @(negedge clk);
      req[1] = 1'b0;
      chk("t4_ack", o_ddr3_ack, 1'b1);
      wr_rdy = 1'b1;
      wait_sig("t4_done", 2, 10);
      chk("t4_req_done", o_req_done, 4'b1000);
      req[3] = 1'b0; wr_rdy = 1'b0;
      repeat (5) @(negedge clk);
      chk("t4_idle_grant", o_grant, 4'b0000);
      chk("t4_idle_busy", o_busy, 1'b0);
      chk("t4_one_grant", 64'(grant_log.size() - base_log), 64'd1);

      // Reset in the middle of a 16-beat write
      req_wr[1] = 1'b1; t_addr[1] = 28'h7654321; t_len[1] = 8'd15;
      cmd_rdy = 1'b1;
      req[1] = 1'b1;
      wait_sig("t5_grant", 0, 10);
      wait_sig("t5_ack", 1, 5);
      wr_rdy = 1'b1;
      repeat (6) @(negedge clk);
      base_done = n_opdone;
      rst_n = 1'b0;
      @(negedge clk);
      chk_all_zero("t5_rst");
      rst_n = 1'b1; req[1] = 1'b0; wr_rdy = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_no_done", 64'(n_opdone - base_done), 64'd0);
      req_wr[0] = 1'b1; t_addr[0] = 28'h0000050; t_len[0] = 8'd0;
      req_wr[3] = 1'b0; t_addr[3] = 28'h0000350; t_len[3] = 8'd1;
      wr_rdy = 1'b1; rd_vld = 1'b1;
      req = 4'b1001;
      wait_sig("t5_grant0", 0, 10);
      chk("t5_first_owner", o_grant, 4'b0001);
      wait_sig("t5_done0", 2, 10);
      req[0] = 1'b0;
      wait_sig("t5_grant3", 0, 10);
      chk("t5_second_owner", o_grant, 4'b1000);
      wait_sig("t5_done3", 2, 10);
      req[3] = 1'b0; wr_rdy = 1'b0; rd_vld = 1'b0;
      @(negedge clk);

      // Single-beat write, request held for a back-to-back re-grant
      req_wr[0] = 1'b1; t_addr[0] = 28'h0000ABC; t_len[0] = 8'd0;
      cmd_rdy = 1'b1; wr_rdy = 1'b1;
      req[0] = 1'b1;
      wait_sig("t6_ack", 1, 10);
      @(negedge clk);
      chk("t6_op_done", o_ddr3_op_done, 1'b1);
      chk("t6_req_done", o_req_done, 4'b0001);
      @(negedge clk);
      chk("t6_gap_grant", o_grant, 4'b0000);
      chk("t6_gap_cmd_vld", o_ddr3_cmd_vld, 1'b0);
      @(negedge clk);
      chk("t6_regrant", o_grant, 4'b0001);
      chk("t6_regrant_cmd_vld", o_ddr3_cmd_vld, 1'b1);
      wait_sig("t6_done2", 2, 10);
      req[0] = 1'b0; wr_rdy = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
